chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/adder_pkg.sv | 11 +
 rtl/chunk_adder.sv | 23 ++
 rtl/chunked_adder.sv | 102 ++++++++++
 tb/tb_chunked_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder; also exposes the carry into the MSB for overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] S,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  for (genvar g = 0; g < CHUNK; g++) begin : g_bit
    assign S[g]     = a[g] ^ b[g] ^ w_c[g];
    assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// Add/subtract unit that processes CHUNK bits per cycle, LSB chunk first,
// with a valid/ready handshake on both sides.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_S;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf;

  logic [CHUNK-1:0] w_ca, w_cb, w_cs;
  logic             w_cout, w_cmsb, w_last;

  assign w_ca   = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_cb   = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_last = (r_cnt == LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (w_ca),
    .b     (w_cb),
    .ci    (r_carry),
    .S     (w_cs),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_S     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (in_valid) begin
          // Subtraction is folded into capture: a + ~b + ~ci.
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub ? ~ci : ci;
          r_cnt   <= '0;
          r_S     <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
        end
        RUN: begin
          r_S[r_cnt*CHUNK +: CHUNK] <= w_cs;
          r_carry                   <= w_cout;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_cmsb ^ w_cout;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign S         = r_S;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder at WIDTH=16, CHUNK=4.
module tb_chunked_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, ci, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, S;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf)
  );

  // Presents one operation, scrambles the inputs after acceptance and waits
  // for out_valid. Leaves the DUT in DONE; lat=-1 on timeout.
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tci, input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb_; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = W'($urandom); ci = ~tci; sub = ~tsub;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #12;
    n_tests++;
    if ({in_ready, out_valid, S, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b S=%h c=%b o=%b, want rdy=1 vld=0 S=0000 c=0 o=0",
               in_ready, out_valid, S, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    drive_op(16'd3, 16'd4, 1'b1, 1'b0, lat);
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_tests++;
    if ({S, cout, ovf} !== {16'h0008, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_3_4_1: S=%h c=%b o=%b want 0008 0 0", S, cout, ovf);
    end
    release_result();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL add_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple();
    int lat;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
      n_fail++; $display("FAIL ripple: S=%h c=%b o=%b lat=%0d want 0000 1 0 4", S, cout, ovf, lat);
    end
    release_result();
  endtask

  task automatic test_ovf();
    int lat;
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_add: S=%h c=%b o=%b want 8000 0 1", S, cout, ovf);
    end
    release_result();
    drive_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_sub: S=%h c=%b o=%b want 7fff 1 1", S, cout, ovf);
    end
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    drive_op(16'd5, 16'd7, 1'b0, 1'b1, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0} || lat !== 4) begin
      n_fail++; $display("FAIL sub_5_7: S=%h c=%b o=%b lat=%0d want fffe 0 0 4", S, cout, ovf, lat);
    end
    release_result();
    drive_op(16'd8, 16'd3, 1'b1, 1'b1, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'h0004, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_8_3_1: S=%h c=%b o=%b want 0004 1 0", S, cout, ovf);
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    int bad = 0;
    drive_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 3 == 0); a = 16'hAAAA; b = 16'h5555; ci = 1'b1; sub = 1'b1;
      @(posedge clk); #1;
      if ({out_valid, in_ready, S, cout, ovf} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0}) bad++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_stable: %0d bad cycles, last S=%h vld=%b rdy=%b want 2345 1 0",
                         bad, S, out_valid, in_ready);
    end
    release_result();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hold_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    // Nothing must have been started by the ignored pulses.
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hold_ignored: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_run();
    int lat;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, S, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_run: rdy=%b vld=%b S=%h c=%b o=%b want 1 0 0000 0 0",
               in_ready, out_valid, S, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    drive_op(16'd8, 16'd8, 1'b1, 1'b0, lat);
    n_tests++;
    if ({S, cout, ovf} !== {16'h0011, 1'b0, 1'b0} || lat !== 4) begin
      n_fail++; $display("FAIL after_reset: S=%h c=%b o=%b lat=%0d want 0011 0 0 4", S, cout, ovf, lat);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_ovf();
    test_sub();
    test_hold();
    test_reset_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
